// File: rtl/tpu_pkg.sv
// Shared constants, FSM encoding and operand skew helper for the systolic array.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package tpu_pkg;

   localparam int TPU_N      = 4;
   localparam int ELEM_BITS  = 8;
   localparam int ACC_BITS   = 32;
   localparam int DATA_BITS  = TPU_N * ELEM_BITS;
   localparam int DATAC_BITS = TPU_N * ACC_BITS;
   localparam int SA_LAT     = 3 * TPU_N - 2;
   localparam int CNT_BITS   = 4;

   // cnt value of the final MAC, at PE(N-1,N-1) with k = N-1
   localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(3 * TPU_N - 3);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sa_state_t;

   // Byte k = cnt - idx of a row/column word; zero outside the 0..N-1 window
   function automatic logic [ELEM_BITS-1:0] skew_byte(
      input logic [DATA_BITS-1:0] word,
      input logic [CNT_BITS-1:0]  cnt,
      input int                   idx
   );
      int k;
      k = int'(cnt) - idx;
      if (k >= 0 && k < TPU_N) begin
         return word[ELEM_BITS*k +: ELEM_BITS];
      end
      return '0;
   endfunction

endpackage

// File: rtl/tpu_pe.sv
// One int8 MAC cell: accumulates a_in*b_in and forwards operands right/down.
// Latency: 1 cycle operand forward, 1 cycle accumulate.
// Backpressure: none; en freezes the cell, clear zeroes it (clear has priority).
module tpu_pe
   import tpu_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        en,
   input  logic signed [ELEM_BITS-1:0] a_in,
   input  logic signed [ELEM_BITS-1:0] b_in,
   output logic signed [ELEM_BITS-1:0] a_out,
   output logic signed [ELEM_BITS-1:0] b_out,
   output logic        [ACC_BITS-1:0]  acc
);

   logic signed [2*ELEM_BITS-1:0] w_prod;
   logic        [ACC_BITS-1:0]    w_prod_ext;
   logic signed [ELEM_BITS-1:0]   r_a;
   logic signed [ELEM_BITS-1:0]   r_b;
   logic        [ACC_BITS-1:0]    r_acc;

   assign w_prod     = a_in * b_in;
   assign w_prod_ext = {{(ACC_BITS-2*ELEM_BITS){w_prod[2*ELEM_BITS-1]}}, w_prod};

   // Accumulate with modulo-2^32 wrap and pass operands to the neighbours
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_a   <= '0;
         r_b   <= '0;
      end else if (clear) begin
         r_acc <= '0;
         r_a   <= '0;
         r_b   <= '0;
      end else if (en) begin
         r_acc <= r_acc + w_prod_ext;
         r_a   <= a_in;
         r_b   <= b_in;
      end
   end

   assign a_out = r_a;
   assign b_out = r_b;
   assign acc   = r_acc;

endmodule

// File: rtl/tpu_sa_core.sv
// 4x4 int8 output-stationary systolic array computing C = A x B for one tile.
// Latency: done rises 3N-2 posedges after the edge that first samples sa_rst_n=1.
// Backpressure: none; A/B must be held stable during RUN, C/done held until sa_rst_n drops.
module tpu_sa_core
   import tpu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sa_rst_n,
   input  logic [DATA_BITS-1:0]  local_buffer_A0,
   input  logic [DATA_BITS-1:0]  local_buffer_A1,
   input  logic [DATA_BITS-1:0]  local_buffer_A2,
   input  logic [DATA_BITS-1:0]  local_buffer_A3,
   input  logic [DATA_BITS-1:0]  local_buffer_B0,
   input  logic [DATA_BITS-1:0]  local_buffer_B1,
   input  logic [DATA_BITS-1:0]  local_buffer_B2,
   input  logic [DATA_BITS-1:0]  local_buffer_B3,
   output logic [DATAC_BITS-1:0] local_buffer_C0,
   output logic [DATAC_BITS-1:0] local_buffer_C1,
   output logic [DATAC_BITS-1:0] local_buffer_C2,
   output logic [DATAC_BITS-1:0] local_buffer_C3,
   output logic                  done
);

   sa_state_t             r_state;
   sa_state_t             w_state_nxt;
   logic [CNT_BITS-1:0]   r_cnt;
   logic                  w_clear;
   logic                  w_en;
   logic                  w_unused;

   logic [DATA_BITS-1:0]        w_a_word [TPU_N];
   logic [DATA_BITS-1:0]        w_b_word [TPU_N];
   logic signed [ELEM_BITS-1:0] w_a      [TPU_N][TPU_N+1];
   logic signed [ELEM_BITS-1:0] w_b      [TPU_N+1][TPU_N];
   logic [ACC_BITS-1:0]         w_acc    [TPU_N][TPU_N];
   logic [DATAC_BITS-1:0]       w_c_row  [TPU_N];

   assign w_a_word[0] = local_buffer_A0;
   assign w_a_word[1] = local_buffer_A1;
   assign w_a_word[2] = local_buffer_A2;
   assign w_a_word[3] = local_buffer_A3;
   assign w_b_word[0] = local_buffer_B0;
   assign w_b_word[1] = local_buffer_B1;
   assign w_b_word[2] = local_buffer_B2;
   assign w_b_word[3] = local_buffer_B3;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Wavefront counter: runs only in RUN, parked at zero otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   // Next state and PE controls; a low sa_rst_n clears on the very edge that samples it
   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_en        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_clear = 1'b1;
            if (sa_rst_n) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!sa_rst_n) begin
               w_clear     = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_en = 1'b1;
               if (r_cnt == LAST_CNT) w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!sa_rst_n) begin
               w_clear     = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_clear     = 1'b1;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign done = (r_state == ST_DONE);

   genvar gi, gj;
   generate
      for (gi = 0; gi < TPU_N; gi++) begin : g_edge
         assign w_a[gi][0] = skew_byte(w_a_word[gi], r_cnt, gi);
         assign w_b[0][gi] = skew_byte(w_b_word[gi], r_cnt, gi);
      end
      for (gi = 0; gi < TPU_N; gi++) begin : g_row
         for (gj = 0; gj < TPU_N; gj++) begin : g_col
            tpu_pe u_pe (
               .clk   (clk),
               .rst   (rst),
               .clear (w_clear),
               .en    (w_en),
               .a_in  (w_a[gi][gj]),
               .b_in  (w_b[gi][gj]),
               .a_out (w_a[gi][gj+1]),
               .b_out (w_b[gi+1][gj]),
               .acc   (w_acc[gi][gj])
            );
         end
         assign w_c_row[gi] = {w_acc[gi][3], w_acc[gi][2], w_acc[gi][1], w_acc[gi][0]};
      end
   endgenerate

   assign local_buffer_C0 = w_c_row[0];
   assign local_buffer_C1 = w_c_row[1];
   assign local_buffer_C2 = w_c_row[2];
   assign local_buffer_C3 = w_c_row[3];

   // Operands leaving the far edge of the array have no consumer
   always_comb begin
      w_unused = 1'b0;
      for (int i = 0; i < TPU_N; i++) begin
         w_unused = w_unused ^ (^w_a[i][TPU_N]) ^ (^w_b[TPU_N][i]);
      end
   end

endmodule

// File: tb/tb_tpu_sa_core.sv
// Directed table vectors plus abort/reset sequences and random tiles vs a matmul model.
// Latency: checks done at exactly SA_LAT posedges after the sampling edge.
// Backpressure: n/a.
module tb_tpu_sa_core;
   import tpu_pkg::*;

   typedef logic [3:0][31:0]  tile_t;
   typedef logic [3:0][127:0] crows_t;
   typedef struct {
      string  nm;
      tile_t  a;
      tile_t  b;
      crows_t c;
      int     hold;
   } vec_t;

   logic   clk = 1'b0;
   logic   rst;
   logic   sa_rst_n;
   tile_t  tb_a;
   tile_t  tb_b;
   logic [127:0] c0, c1, c2, c3;
   crows_t c_all;
   logic   done;
   int     total = 0;
   int     bad   = 0;
   vec_t   tbl [5];

   assign c_all = {c3, c2, c1, c0};

   always #5 clk = ~clk;

   tpu_sa_core dut (
      .clk             (clk),
      .rst             (rst),
      .sa_rst_n        (sa_rst_n),
      .local_buffer_A0 (tb_a[0]),
      .local_buffer_A1 (tb_a[1]),
      .local_buffer_A2 (tb_a[2]),
      .local_buffer_A3 (tb_a[3]),
      .local_buffer_B0 (tb_b[0]),
      .local_buffer_B1 (tb_b[1]),
      .local_buffer_B2 (tb_b[2]),
      .local_buffer_B3 (tb_b[3]),
      .local_buffer_C0 (c0),
      .local_buffer_C1 (c1),
      .local_buffer_C2 (c2),
      .local_buffer_C3 (c3),
      .done            (done)
   );

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference: C[i][j] = sum_k A[i][k]*B[k][j], signed bytes, 32-bit wrap
   function automatic crows_t mm(input tile_t a, input tile_t b);
      crows_t c;
      logic signed [7:0]  x, y;
      logic signed [31:0] s;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int k = 0; k < 4; k++) begin
               x = a[i][8*k +: 8];
               y = b[j][8*k +: 8];
               s = s + 32'(x * y);
            end
            c[i][32*j +: 32] = s;
         end
      end
      return c;
   endfunction

   // Raise sa_rst_n with a tile, check latency and result, optionally hold, then clear
   task automatic run_tile(input string nm, input tile_t a, input tile_t b,
                           input crows_t exp, input int hold, input int gap);
      int   cyc;
      logic ok;
      @(negedge clk);
      tb_a     = a;
      tb_b     = b;
      sa_rst_n = 1'b1;
      // first negedge counted follows the sampling posedge, so done shows at SA_LAT+1
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk($sformatf("%s latency", nm), 512'(cyc), 512'(SA_LAT + 1));
      for (int r = 0; r < 4; r++) begin
         chk($sformatf("%s C%0d", nm, r), 512'(c_all[r]), 512'(exp[r]));
      end
      if (hold > 0) begin
         ok = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            if (done !== 1'b1 || c_all !== exp) ok = 1'b0;
         end
         chk($sformatf("%s hold", nm), 512'(ok), 512'(1));
      end
      sa_rst_n = 1'b0;
      @(negedge clk);
      chk($sformatf("%s clear", nm), 512'({done, c_all}), 512'(0));
      repeat (gap - 1) @(negedge clk);
   endtask

   initial begin
      tile_t a, b;
      int    cyc;

      tbl[0] = '{"ident",
                 {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001},
                 {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201},
                 {128'h00000010_0000000C_00000008_00000004,
                  128'h0000000F_0000000B_00000007_00000003,
                  128'h0000000E_0000000A_00000006_00000002,
                  128'h0000000D_00000009_00000005_00000001}, 0};
      tbl[1] = '{"neg128sq", {4{32'h80808080}}, {4{32'h80808080}}, {16{32'h00010000}}, 0};
      tbl[2] = '{"plus_minus", {4{32'h01010101}}, {4{32'hFFFFFFFF}}, {16{32'hFFFFFFFC}}, 20};
      tbl[3] = '{"max_sq", {4{32'h7F7F7F7F}}, {4{32'h7F7F7F7F}}, {16{32'h0000FC04}}, 0};
      tbl[4] = '{"max_min", {4{32'h7F7F7F7F}}, {4{32'h80808080}}, {16{32'hFFFF0200}}, 0};

      rst      = 1'b1;
      sa_rst_n = 1'b0;
      tb_a     = '0;
      tb_b     = '0;
      repeat (2) @(negedge clk);
      chk("reset", 512'({done, c_all}), 512'(0));
      rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         run_tile(tbl[v].nm, tbl[v].a, tbl[v].b, tbl[v].c, tbl[v].hold, 2);
      end

      // abort: sa_rst_n sampled low while cnt=5, then restart with a different tile
      @(negedge clk);
      tb_a     = tbl[1].a;
      tb_b     = tbl[1].b;
      sa_rst_n = 1'b1;
      repeat (6) @(negedge clk);
      sa_rst_n = 1'b0;
      @(negedge clk);
      chk("abort idle", 512'({done, c_all}), 512'(0));
      run_tile("abort rerun", tbl[0].a, tbl[0].b, tbl[0].c, 0, 2);

      // async reset while cnt=7, between clock edges
      @(negedge clk);
      tb_a     = tbl[0].a;
      tb_b     = tbl[0].b;
      sa_rst_n = 1'b1;
      repeat (8) @(negedge clk);
      #2;
      rst      = 1'b1;
      sa_rst_n = 1'b0;
      #1;
      chk("rst mid-run", 512'({done, c_all}), 512'(0));
      @(negedge clk);
      rst = 1'b0;
      run_tile("after rst run", tbl[3].a, tbl[3].b, tbl[3].c, 0, 2);

      // async reset while holding a finished result
      @(negedge clk);
      tb_a     = tbl[1].a;
      tb_b     = tbl[1].b;
      sa_rst_n = 1'b1;
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("pre-rst done", 512'(done), 512'(1));
      #2;
      rst      = 1'b1;
      sa_rst_n = 1'b0;
      #1;
      chk("rst in done", 512'({done, c_all}), 512'(0));
      @(negedge clk);
      rst = 1'b0;
      run_tile("after rst done", tbl[2].a, tbl[2].b, tbl[2].c, 0, 2);

      for (int n = 0; n < 500; n++) begin
         a = {$urandom(), $urandom(), $urandom(), $urandom()};
         b = {$urandom(), $urandom(), $urandom(), $urandom()};
         run_tile($sformatf("rnd%0d", n), a, b, mm(a, b), 0, int'($urandom_range(1, 5)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
